// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: registers one ALU result, runs load/store with bounded wait, emits write-back bundle.
// Latency 1 cycle (non-memory/illegal) or ack/timeout + 1; InReady only when IDLE or HOLD draining with OutReady.
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        ClockInput,
    input  logic        ResetInputN,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] AluResult,
    input  logic [31:0] StoreData,
    input  logic [4:0]  DestReg,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        Branch,
    input  logic        ZeroFlag,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutData,
    output logic [4:0]  OutDestReg,
    output logic        OutRegWrite,
    output logic        BranchTaken,
    output logic        MemError
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          regwrite_q;
    logic          accept;
    logic          is_mem;
    logic          legal;

    assign InReady = ResetInputN & ((state == IDLE) | ((state == HOLD) & OutReady));
    assign accept  = InValid & InReady;
    assign is_mem  = MemRead | MemWrite;
    assign legal   = (MemRead ^ MemWrite) & (AluResult[1:0] == 2'b00);

    always_ff @(posedge ClockInput or negedge ResetInputN) begin
        if (!ResetInputN) begin
            state       <= IDLE;
            cnt         <= '0;
            regwrite_q  <= 1'b0;
            MemReq      <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            OutValid    <= 1'b0;
            OutData     <= '0;
            OutDestReg  <= '0;
            OutRegWrite <= 1'b0;
            BranchTaken <= 1'b0;
            MemError    <= 1'b0;
        end else begin
            BranchTaken <= 1'b0;
            MemError    <= 1'b0;
            if (accept) begin
                BranchTaken <= Branch & ZeroFlag;
                OutDestReg  <= DestReg;
                OutData     <= AluResult;
                if (!is_mem) begin
                    OutRegWrite <= RegWrite;
                    OutValid    <= 1'b1;
                    state       <= HOLD;
                end else if (legal) begin
                    MemAddr    <= AluResult;
                    MemWData   <= StoreData;
                    MemWe      <= MemWrite;
                    MemReq     <= 1'b1;
                    regwrite_q <= RegWrite;
                    cnt        <= '0;
                    OutValid   <= 1'b0;
                    state      <= ACCESS;
                end else begin
                    MemError    <= 1'b1;
                    OutRegWrite <= 1'b0;
                    OutValid    <= 1'b1;
                    state       <= HOLD;
                end
            end else if (state == HOLD) begin
                if (OutReady) begin
                    OutValid <= 1'b0;
                    state    <= IDLE;
                end
            end else if (state == ACCESS) begin
                // An ack arriving on the final allowed cycle still completes normally.
                if (MemAck) begin
                    MemReq      <= 1'b0;
                    OutValid    <= 1'b1;
                    state       <= HOLD;
                    if (!MemWe) begin
                        OutData     <= MemRData;
                        OutRegWrite <= regwrite_q;
                    end else begin
                        OutRegWrite <= 1'b0;
                    end
                end else if (cnt == LAST_CNT) begin
                    MemReq      <= 1'b0;
                    MemError    <= 1'b1;
                    OutRegWrite <= 1'b0;
                    OutValid    <= 1'b1;
                    state       <= HOLD;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: random and directed instructions against a transaction-level model.
`timescale 1ns/1ps
module tb_memory_access_stage;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InValid, InReady;
    logic [31:0] AluResult, StoreData;
    logic [4:0]  DestReg;
    logic        MemRead, MemWrite, RegWrite, Branch, ZeroFlag;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        OutValid, OutReady;
    logic [31:0] OutData;
    logic [4:0]  OutDestReg;
    logic        OutRegWrite, BranchTaken, MemError;

    memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .ClockInput(clk), .ResetInputN(rst_n),
        .InValid(InValid), .InReady(InReady),
        .AluResult(AluResult), .StoreData(StoreData), .DestReg(DestReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .Branch(Branch), .ZeroFlag(ZeroFlag),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutDestReg(OutDestReg), .OutRegWrite(OutRegWrite),
        .BranchTaken(BranchTaken), .MemError(MemError)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [4:0] dest; logic rw; } out_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; int lat; logic [31:0] rdata; int exp_hi; } req_t;

    out_t out_q[$];
    req_t req_q[$];
    int   total = 0, bad = 0;
    int   exp_err = 0, exp_br = 0, err_seen = 0, br_seen = 0;
    int   busy = 0;
    logic force_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Issue one instruction; the expected write-back and memory request are derived from the rules, not the RTL.
    task automatic send(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dest,
                        input logic mr, input logic mw, input logic rw, input logic br, input logic zf,
                        input int lat, input logic [31:0] rd, output int waited);
        logic mem, illegal, tmo;
        out_t o;
        req_t r;
        int   guard;
        mem     = mr | mw;
        illegal = (mr & mw) || (mem && alu[1:0] != 2'b00);
        tmo     = mem && !illegal && (lat == 0 || lat > T);
        if (mem && !illegal) begin
            InValid = 1'b0;
            guard = 0;
            while (busy != 0 || req_q.size() != 0) begin
                @(negedge clk);
                guard++;
                if (guard > 300) begin
                    $display("FAIL mem_idle_wait: still busy after %0d cycles, required idle", guard);
                    $fatal(1, "memory responder stuck");
                end
            end
            r.addr = alu; r.we = mw; r.wdata = sd; r.rdata = rd;
            r.lat  = (lat < 0) ? 0 : lat;
            r.exp_hi = (lat < 0) ? -1 : ((lat >= 1 && lat <= T) ? lat : T);
            req_q.push_back(r);
        end
        o.dest = dest;
        if (!mem)               begin o.data = alu; o.rw = rw;   end
        else if (illegal || tmo) begin o.data = alu; o.rw = 1'b0; end
        else if (mr)            begin o.data = rd;  o.rw = rw;   end
        else                    begin o.data = alu; o.rw = 1'b0; end
        out_q.push_back(o);
        if (illegal || tmo) exp_err++;
        if (br & zf) exp_br++;

        AluResult = alu; StoreData = sd; DestReg = dest;
        MemRead = mr; MemWrite = mw; RegWrite = rw; Branch = br; ZeroFlag = zf;
        InValid = 1'b1;
        waited = 0;
        #1;
        while (!InReady) begin
            @(negedge clk); #1;
            waited++;
            if (waited > 500) begin
                $display("FAIL accept_wait: InReady low for %0d cycles, required 1", waited);
                $fatal(1, "stage never accepted");
            end
        end
        @(posedge clk);
        @(negedge clk);
        InValid = 1'b0;
        chk("branch_pulse", 32'(BranchTaken), 32'(br & zf));
        chk("illegal_error", 32'(MemError), 32'(illegal));
        if (illegal) chk("no_req_illegal", 32'(MemReq), 32'd0);
    endtask

    // Downstream backpressure
    initial begin
        OutReady = 1'b0;
        forever begin
            @(posedge clk);
            #2 OutReady = force_ready | ($urandom_range(0, 3) != 0);
        end
    end

    // Memory model: checks request fields and duration, replies after the planned latency
    initial begin
        req_t cur;
        int   el, hi;
        MemAck = 1'b0; MemRData = '0; el = 0; hi = 0;
        forever begin
            @(negedge clk);
            MemAck = 1'b0;
            MemRData = $urandom;
            if (busy == 0 && MemReq) begin
                if (req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: MemReq=1 addr=%h, required 0", MemAddr);
                end else begin
                    cur = req_q.pop_front();
                    busy = 1; el = 0; hi = 0;
                end
            end
            if (busy != 0) begin
                el++;
                if (MemReq) begin
                    hi++;
                    chk("mem_addr", MemAddr, cur.addr);
                    chk("mem_we", 32'(MemWe), 32'(cur.we));
                    if (cur.we) chk("mem_wdata", MemWData, cur.wdata);
                end
                if (el == cur.lat) begin
                    MemAck = 1'b1;
                    MemRData = cur.rdata;
                end
                if (!MemReq && (cur.lat == 0 || el > cur.lat)) begin
                    if (cur.exp_hi >= 0) chk("req_cycles", hi, cur.exp_hi);
                    busy = 0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on each write-back handshake, checks stall stability
    initial begin
        out_t e, sv;
        logic stall;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (MemError) err_seen++;
            if (BranchTaken) br_seen++;
            if (OutValid) begin
                if (stall) begin
                    chk("hold_data", OutData, sv.data);
                    chk("hold_dest", 32'(OutDestReg), 32'(sv.dest));
                    chk("hold_rw", 32'(OutRegWrite), 32'(sv.rw));
                end
                if (OutReady) begin
                    if (out_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL out_unexpected: OutValid=1 data=%h, required no output", OutData);
                    end else begin
                        e = out_q.pop_front();
                        chk("out_data", OutData, e.data);
                        chk("out_dest", 32'(OutDestReg), 32'(e.dest));
                        chk("out_regwrite", 32'(OutRegWrite), 32'(e.rw));
                    end
                    stall = 1'b0;
                end else begin
                    chk("inready_stall", 32'(InReady), 32'd0);
                    sv.data = OutData; sv.dest = OutDestReg; sv.rw = OutRegWrite;
                    stall = 1'b1;
                end
            end else begin
                if (stall) chk("valid_held", 32'(OutValid), 32'd1);
                stall = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, kind, lr, guard, lat;
        logic [31:0] alu, sd;
        logic [4:0]  dest;
        logic        mr, mw, rw, br, zf;

        rst_n = 1'b0; InValid = 1'b1;
        AluResult = 32'h1234_5678; StoreData = 32'h9; DestReg = 5'd4;
        MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; Branch = 1'b1; ZeroFlag = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_inready", 32'(InReady), 32'd0);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_memwe", 32'(MemWe), 32'd0);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_outrw", 32'(OutRegWrite), 32'd0);
        chk("rst_branch", 32'(BranchTaken), 32'd0);
        chk("rst_memerr", 32'(MemError), 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_memwdata", MemWData, 32'd0);
        chk("rst_outdata", OutData, 32'd0);
        chk("rst_outdest", 32'(OutDestReg), 32'd0);
        InValid = 1'b0;
        rst_n = 1'b1;
        #1 chk("release_inready", 32'(InReady), 32'd1);
        @(negedge clk);
        chk("release_no_accept", 32'(OutValid), 32'd0);

        force_ready = 1'b1;
        repeat (2) @(negedge clk);
        send(32'd5, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'd0, w);
        send(32'd6, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'd0, w);
        chk("stream_gap_6", w, 0);
        send(32'd7, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'd0, w);
        chk("stream_gap_7", w, 0);
        send(32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 32'hDEAD_BEEF, w);
        send(32'h104, 32'h55, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'h0, w);
        send(32'h102, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 32'h0, w);
        send(32'h108, 32'h1, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 32'h0, w);
        send(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0, w);
        send(32'h4, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, w);
        send(32'h200, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0, w);
        send(32'h204, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, T, 32'h1234_5678, w);
        send(32'h208, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, T + 3, 32'hBAD0_BAD0, w);
        send(32'h77, 32'h0, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0, w);

        force_ready = 1'b0;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 5);
            alu = $urandom; sd = $urandom; dest = 5'($urandom);
            rw = 1'($urandom); br = 1'($urandom); zf = 1'($urandom);
            mr = 1'b0; mw = 1'b0;
            case (kind)
                2: begin mr = 1'b1; alu[1:0] = 2'b00; end
                3: begin mw = 1'b1; alu[1:0] = 2'b00; end
                4: begin mr = 1'($urandom); mw = ~mr; alu[1:0] = 2'($urandom_range(1, 3)); end
                5: begin mr = 1'b1; mw = 1'b1; end
                default: ;
            endcase
            lr = $urandom_range(0, 9);
            if (lr <= 5)      lat = $urandom_range(1, 4);
            else if (lr == 6) lat = T;
            else if (lr == 7) lat = T - 1;
            else if (lr == 8) lat = 0;
            else              lat = $urandom_range(T + 1, T + 4);
            send(alu, sd, dest, mr, mw, rw, br, zf, lat, $urandom, w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        force_ready = 1'b1;
        guard = 0;
        while ((out_q.size() != 0 || busy != 0 || req_q.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_outputs", out_q.size(), 0);
        chk("drain_memory", busy, 0);
        chk("error_pulses", err_seen, exp_err);
        chk("branch_pulses", br_seen, exp_br);

        send(32'h300, 32'h0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, 32'h0, w);
        repeat (3) @(negedge clk);
        chk("req_before_reset", 32'(MemReq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_memreq", 32'(MemReq), 32'd0);
        chk("async_reset_outvalid", 32'(OutValid), 32'd0);
        chk("async_reset_inready", 32'(InReady), 32'd0);
        out_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_outvalid", 32'(OutValid), 32'd0);
        chk("post_reset_memreq", 32'(MemReq), 32'd0);
        chk("post_reset_idle", 32'(InReady), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
